// File: rtl/booth_mul_arbiter_if.sv
// Bundle of request, response and multiplier-side signals for booth_mul_arbiter.
// The slave view belongs to the arbiter. The master view belongs to the environment,
// which means the requesters, the result consumer and the multiplier.
interface booth_mul_arbiter_if #(
    parameter int WIDTH = 8
);
    logic                 req0;
    logic                 req1;
    logic [WIDTH-1:0]     a0;
    logic [WIDTH-1:0]     b0;
    logic [WIDTH-1:0]     a1;
    logic [WIDTH-1:0]     b1;
    logic                 gnt0;
    logic                 gnt1;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [2*WIDTH-1:0]   rsp_data;
    logic                 rsp_err;
    logic                 busy;
    logic                 mul_go;
    logic [WIDTH-1:0]     mul_a;
    logic [WIDTH-1:0]     mul_b;
    logic                 mul_rst;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_p;

    modport slave (
        input  req0, req1, a0, b0, a1, b1, rsp_ready, mul_done, mul_p,
        output gnt0, gnt1, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
               mul_go, mul_a, mul_b, mul_rst
    );

    modport master (
        output req0, req1, a0, b0, a1, b1, rsp_ready, mul_done, mul_p,
        input  gnt0, gnt1, rsp_valid, rsp_id, rsp_data, rsp_err, busy,
               mul_go, mul_a, mul_b, mul_rst
    );
endinterface

// File: rtl/booth_mul_arbiter.sv
// This module is a round-robin arbiter that lets two requesters share one external Booth multiplier.
// A watchdog aborts a multiply that never completes and pulses the multiplier's recovery reset.
//
// state | meaning
// IDLE  | no transaction; pick a winner and latch its operands when any req is high
// START | one cycle: mul_go and the winner's gnt asserted together
// WAIT  | waiting on mul_done; the watchdog counts cycles spent here
// RESP  | result presented on rsp_*; held until rsp_ready
module booth_mul_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               RST,
    booth_mul_arbiter_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic                 winner, winner_nxt;
    logic                 last_grant, last_grant_nxt;
    logic [WIDTH-1:0]     a_q, a_nxt;
    logic [WIDTH-1:0]     b_q, b_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [2*WIDTH-1:0]   data_q, data_nxt;
    logic                 err_q, err_nxt;
    logic                 mrst_q, mrst_nxt;
    logic                 pick1;

    // Requester 1 wins when it is the only requester, or when there is a tie and requester 0 was granted last.
    assign pick1 = bus.req1 && (!bus.req0 || !last_grant);

    // State register and datapath registers; reset makes requester 0 win the first tie
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            winner     <= 1'b0;
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            cnt        <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            mrst_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            winner     <= winner_nxt;
            last_grant <= last_grant_nxt;
            a_q        <= a_nxt;
            b_q        <= b_nxt;
            cnt        <= cnt_nxt;
            data_q     <= data_nxt;
            err_q      <= err_nxt;
            mrst_q     <= mrst_nxt;
        end
    end

    // Next-state logic; a completion that arrives in the last watchdog cycle still counts as a normal result
    always_comb begin
        state_nxt      = state;
        winner_nxt     = winner;
        last_grant_nxt = last_grant;
        a_nxt          = a_q;
        b_nxt          = b_q;
        cnt_nxt        = cnt;
        data_nxt       = data_q;
        err_nxt        = err_q;
        mrst_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    winner_nxt     = pick1;
                    last_grant_nxt = pick1;
                    a_nxt          = pick1 ? bus.a1 : bus.a0;
                    b_nxt          = pick1 ? bus.b1 : bus.b0;
                    state_nxt      = START;
                end
            end
            START: begin
                cnt_nxt   = '0;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.mul_done) begin
                    data_nxt  = bus.mul_p;
                    err_nxt   = 1'b0;
                    state_nxt = RESP;
                end else if (cnt == CNT_LAST) begin
                    data_nxt  = '0;
                    err_nxt   = 1'b1;
                    mrst_nxt  = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy      = (state != IDLE);
    assign bus.mul_go    = (state == START);
    assign bus.gnt0      = (state == START) && !winner;
    assign bus.gnt1      = (state == START) && winner;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = winner;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    assign bus.mul_a     = a_q;
    assign bus.mul_b     = b_q;
    assign bus.mul_rst   = mrst_q;
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Self-checking bench for booth_mul_arbiter.
// A behavioural multiplier answers mul_go after a programmable latency, or never answers.
// Expected grants and products come from round-robin rules and from signed arithmetic.
module tb_booth_mul_arbiter;
    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 64;
    localparam int PW      = 2 * WIDTH;

    logic clk = 1'b0;
    logic RST;
    int   total = 0;
    int   bad   = 0;
    int   mul_lat = 1;      // -1: multiplier never completes
    bit   exp_last;         // model of the last granted requester

    booth_mul_arbiter_if #(.WIDTH(WIDTH)) bus();

    booth_mul_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] ref_prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int ia;
        int ib;
        ia = $signed(a);
        ib = $signed(b);
        return PW'(ia * ib);
    endfunction

    // Behavioural multiplier: raises mul_done for one cycle, mul_lat cycles after it sees mul_go
    initial begin
        int  left;
        bit  mbusy;
        logic [PW-1:0] prod;
        bus.mul_done = 1'b0;
        bus.mul_p    = '0;
        mbusy = 0; left = 0; prod = '0;
        forever begin
            @(negedge clk);
            bus.mul_done = 1'b0;
            if (RST) begin
                mbusy = 0;
            end else begin
                if (bus.mul_rst) mbusy = 0;
                if (bus.mul_go) begin
                    mbusy = 1;
                    left  = mul_lat;
                    prod  = ref_prod(bus.mul_a, bus.mul_b);
                end else if (mbusy && left > 0) begin
                    left--;
                    if (left == 0) begin
                        bus.mul_done = 1'b1;
                        bus.mul_p    = prod;
                        mbusy        = 0;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic do_reset();
        RST = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        RST = 1'b0;
        exp_last = 1'b1;
        @(negedge clk);
    endtask

    task automatic raise_req(input int who);
        if (who == 0) begin
            bus.a0 = WIDTH'($urandom); bus.b0 = WIDTH'($urandom); bus.req0 = 1'b1;
        end else begin
            bus.a1 = WIDTH'($urandom); bus.b1 = WIDTH'($urandom); bus.req1 = 1'b1;
        end
    endtask

    task automatic wait_valid(input int limit, output int cyc, output bit ok, output bit gseen);
        cyc = 0; ok = 0; gseen = 0;
        while (cyc < limit && !ok) begin
            @(negedge clk);
            cyc++;
            if (bus.gnt0 || bus.gnt1) gseen = 1;
            if (bus.rsp_valid) ok = 1;
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rsp_ready = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.gnt0, bus.gnt1, bus.mul_go, bus.mul_rst} !== 4'b0000) begin
            bad++; $display("FAIL reset_pulses got=%b want=0000", {bus.gnt0, bus.gnt1, bus.mul_go, bus.mul_rst});
        end
        total++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.busy} !== 4'b0000) begin
            bad++; $display("FAIL reset_status got=%b want=0000", {bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.busy});
        end
        total++;
        if ({bus.rsp_data, bus.mul_a, bus.mul_b} !== '0) begin
            bad++; $display("FAIL reset_data got=%h/%h/%h want=0", bus.rsp_data, bus.mul_a, bus.mul_b);
        end
        RST = 1'b0;
        exp_last = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc; bit ok; bit gs;
        bus.a0 = 8'd3; bus.b0 = 8'hFE; bus.req0 = 1'b1; mul_lat = 3;
        @(negedge clk);
        total++;
        if ({bus.gnt0, bus.gnt1, bus.mul_go} !== 3'b101) begin
            bad++; $display("FAIL basic_gnt got=%b want=101", {bus.gnt0, bus.gnt1, bus.mul_go});
        end
        total++;
        if ({bus.mul_a, bus.mul_b} !== 16'h03FE) begin
            bad++; $display("FAIL basic_ops got=%h want=03fe", {bus.mul_a, bus.mul_b});
        end
        bus.req0 = 1'b0; exp_last = 1'b0;
        wait_valid(TIMEOUT + 10, cyc, ok, gs);
        total++;
        if (!ok || cyc != 4) begin
            bad++; $display("FAIL basic_latency got=%0d want=4 (valid=%0d)", cyc, ok);
        end
        total++;
        if ({bus.rsp_id, bus.rsp_err, bus.mul_rst, bus.rsp_data} !== {3'b000, 16'hFFFA}) begin
            bad++; $display("FAIL basic_rsp got id=%b err=%b rst=%b data=%h want 0/0/0/fffa",
                            bus.rsp_id, bus.rsp_err, bus.mul_rst, bus.rsp_data);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        total++;
        if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
            bad++; $display("FAIL basic_idle got=%b want=00", {bus.rsp_valid, bus.busy});
        end
    endtask

    task automatic test_random();
        int cyc; bit ok; bit gs; bit exp_w; int hold;
        logic [WIDTH-1:0] ea, eb;
        for (int it = 0; it < 24; it++) begin
            if (!bus.req0 && $urandom_range(0, 1) == 1) raise_req(0);
            if (!bus.req1 && $urandom_range(0, 1) == 1) raise_req(1);
            if (!bus.req0 && !bus.req1) raise_req(int'($urandom_range(0, 1)));
            exp_w = (bus.req0 && bus.req1) ? !exp_last : bus.req1;
            ea = exp_w ? bus.a1 : bus.a0;
            eb = exp_w ? bus.b1 : bus.b0;
            mul_lat = int'($urandom_range(1, 12));
            @(negedge clk);
            total++;
            if ({bus.gnt1, bus.gnt0, bus.mul_go} !== {exp_w, !exp_w, 1'b1}) begin
                bad++; $display("FAIL rnd_gnt it=%0d got=%b want=%b", it, {bus.gnt1, bus.gnt0, bus.mul_go}, {exp_w, !exp_w, 1'b1});
            end
            total++;
            if ({bus.mul_a, bus.mul_b} !== {ea, eb}) begin
                bad++; $display("FAIL rnd_ops it=%0d got=%h want=%h", it, {bus.mul_a, bus.mul_b}, {ea, eb});
            end
            exp_last = exp_w;
            if (exp_w) bus.req1 = 1'b0; else bus.req0 = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                if (exp_w && !bus.req0) raise_req(0);
                if (!exp_w && !bus.req1) raise_req(1);
            end
            wait_valid(TIMEOUT + 10, cyc, ok, gs);
            total++;
            if (!ok || cyc != mul_lat + 1 || gs) begin
                bad++; $display("FAIL rnd_wait it=%0d got cyc=%0d gnt_seen=%0d want cyc=%0d gnt_seen=0", it, cyc, gs, mul_lat + 1);
            end
            hold = int'($urandom_range(0, 3));
            repeat (hold) @(negedge clk);
            total++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data} !== {1'b1, exp_w, 1'b0, ref_prod(ea, eb)}) begin
                bad++; $display("FAIL rnd_rsp it=%0d got v=%b id=%b err=%b data=%h want 1/%b/0/%h",
                                it, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data, exp_w, ref_prod(ea, eb));
            end
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            bus.rsp_ready = 1'b0;
            total++;
            if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
                bad++; $display("FAIL rnd_idle it=%0d got=%b want=00", it, {bus.rsp_valid, bus.busy});
            end
        end
    endtask

    task automatic test_tie_order();
        int gq[$]; int rq[$]; int n;
        do_reset();
        bus.a0 = 8'd5; bus.b0 = 8'd7; bus.a1 = 8'hFD; bus.b1 = 8'd4;
        bus.req0 = 1'b1; bus.req1 = 1'b1; bus.rsp_ready = 1'b1; mul_lat = 2;
        n = 0;
        while (n < 200 && rq.size() < 4) begin
            @(negedge clk);
            n++;
            if (bus.gnt0) gq.push_back(0);
            if (bus.gnt1) gq.push_back(1);
            if (bus.rsp_valid) begin
                rq.push_back(int'(bus.rsp_id));
                total++;
                if (bus.rsp_data !== (bus.rsp_id ? 16'hFFF4 : 16'd35)) begin
                    bad++; $display("FAIL tie_data id=%b got=%h want=%h", bus.rsp_id, bus.rsp_data, bus.rsp_id ? 16'hFFF4 : 16'd35);
                end
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.rsp_ready = 1'b0;
        total++;
        if (gq.size() < 4 || gq[0] != 0 || gq[1] != 1 || gq[2] != 0 || gq[3] != 1) begin
            bad++; $display("FAIL tie_grant_order got=%p want=0,1,0,1", gq);
        end
        total++;
        if (rq.size() != 4 || rq[0] != 0 || rq[1] != 1 || rq[2] != 0 || rq[3] != 1) begin
            bad++; $display("FAIL tie_rsp_id got=%p want=0,1,0,1", rq);
        end
    endtask

    task automatic test_timeout();
        int cyc; bit ok; bit gs;
        do_reset();
        mul_lat = -1;
        bus.a0 = 8'd9; bus.b0 = 8'd9; bus.req0 = 1'b1;
        @(negedge clk);
        total++;
        if (bus.gnt0 !== 1'b1) begin
            bad++; $display("FAIL to_gnt got=%b want=1", bus.gnt0);
        end
        bus.req0 = 1'b0;
        wait_valid(TIMEOUT + 20, cyc, ok, gs);
        total++;
        if (!ok || cyc != TIMEOUT + 1) begin
            bad++; $display("FAIL to_latency got=%0d want=%0d (valid=%0d)", cyc, TIMEOUT + 1, ok);
        end
        total++;
        if ({bus.mul_rst, bus.rsp_err, bus.rsp_data} !== {2'b11, 16'h0000}) begin
            bad++; $display("FAIL to_abort got rst=%b err=%b data=%h want 1/1/0000", bus.mul_rst, bus.rsp_err, bus.rsp_data);
        end
        @(negedge clk);
        total++;
        if ({bus.mul_rst, bus.rsp_valid, bus.rsp_err} !== 3'b011) begin
            bad++; $display("FAIL to_rst_pulse got=%b want=011", {bus.mul_rst, bus.rsp_valid, bus.rsp_err});
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_done_at_limit();
        int cyc; bit ok; bit gs; bit saw_rst;
        do_reset();
        mul_lat = TIMEOUT;
        bus.a1 = 8'h80; bus.b1 = 8'h80; bus.req1 = 1'b1;
        @(negedge clk);
        bus.req1 = 1'b0;
        wait_valid(TIMEOUT + 20, cyc, ok, gs);
        saw_rst = bus.mul_rst;
        total++;
        if (!ok || cyc != TIMEOUT + 1) begin
            bad++; $display("FAIL lim_latency got=%0d want=%0d (valid=%0d)", cyc, TIMEOUT + 1, ok);
        end
        total++;
        if ({bus.rsp_id, bus.rsp_err, saw_rst, bus.rsp_data} !== {3'b100, 16'h4000}) begin
            bad++; $display("FAIL lim_rsp got id=%b err=%b rst=%b data=%h want 1/0/0/4000",
                            bus.rsp_id, bus.rsp_err, saw_rst, bus.rsp_data);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_hold();
        int cyc; bit ok; bit gs; int unstable; bit g1;
        logic [PW-1:0] snap;
        do_reset();
        mul_lat = 2;
        raise_req(0);
        @(negedge clk);
        bus.req0 = 1'b0;
        wait_valid(TIMEOUT + 10, cyc, ok, gs);
        snap = ref_prod(bus.a0, bus.b0);
        raise_req(1);
        unstable = 0; g1 = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.gnt1) g1 = 1;
            if (!bus.rsp_valid || bus.rsp_data !== snap || bus.rsp_id !== 1'b0 || bus.rsp_err !== 1'b0) unstable++;
        end
        total++;
        if (unstable != 0 || !ok) begin
            bad++; $display("FAIL hold_stable got unstable=%0d valid=%0d want 0/1", unstable, ok);
        end
        total++;
        if (g1) begin
            bad++; $display("FAIL hold_no_gnt got gnt1_seen=1 want 0");
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        total++;
        if ({bus.rsp_valid, bus.gnt1} !== 2'b00) begin
            bad++; $display("FAIL hold_idle got=%b want=00", {bus.rsp_valid, bus.gnt1});
        end
        @(negedge clk);
        total++;
        if ({bus.gnt1, bus.mul_go} !== 2'b11) begin
            bad++; $display("FAIL hold_served got=%b want=11", {bus.gnt1, bus.mul_go});
        end
        bus.req1 = 1'b0;
        wait_valid(TIMEOUT + 10, cyc, ok, gs);
        total++;
        if (!ok || {bus.rsp_id, bus.rsp_data} !== {1'b1, ref_prod(bus.a1, bus.b1)}) begin
            bad++; $display("FAIL hold_rsp1 got id=%b data=%h want 1/%h", bus.rsp_id, bus.rsp_data, ref_prod(bus.a1, bus.b1));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_rst_mid();
        int cyc; bit ok; bit gs; bit g;
        do_reset();
        mul_lat = -1;
        raise_req(0);
        @(negedge clk);
        bus.req0 = 1'b0;
        repeat (5) @(negedge clk);
        #2 RST = 1'b1;
        #1;
        total++;
        if ({bus.busy, bus.mul_go, bus.gnt0, bus.gnt1, bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.mul_rst} !== 8'h00) begin
            bad++; $display("FAIL rst_async_ctrl got=%b want=00000000",
                            {bus.busy, bus.mul_go, bus.gnt0, bus.gnt1, bus.rsp_valid, bus.rsp_err, bus.rsp_id, bus.mul_rst});
        end
        total++;
        if ({bus.rsp_data, bus.mul_a, bus.mul_b} !== '0) begin
            bad++; $display("FAIL rst_async_data got=%h/%h/%h want=0", bus.rsp_data, bus.mul_a, bus.mul_b);
        end
        @(negedge clk);
        RST = 1'b0;
        exp_last = 1'b1;
        g = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1 || bus.busy) g = 1;
        end
        total++;
        if (g) begin
            bad++; $display("FAIL rst_no_regrant got activity=1 want 0");
        end
        mul_lat = 4;
        raise_req(1);
        @(negedge clk);
        total++;
        if ({bus.gnt1, bus.gnt0, bus.mul_go} !== 3'b101) begin
            bad++; $display("FAIL rst_req1_gnt got=%b want=101", {bus.gnt1, bus.gnt0, bus.mul_go});
        end
        bus.req1 = 1'b0;
        wait_valid(TIMEOUT + 10, cyc, ok, gs);
        total++;
        if (!ok || cyc != 5 || {bus.rsp_id, bus.rsp_err, bus.rsp_data} !== {2'b10, ref_prod(bus.a1, bus.b1)}) begin
            bad++; $display("FAIL rst_req1_rsp got cyc=%0d id=%b err=%b data=%h want 5/1/0/%h",
                            cyc, bus.rsp_id, bus.rsp_err, bus.rsp_data, ref_prod(bus.a1, bus.b1));
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_tie_order();
        test_timeout();
        test_done_at_limit();
        test_hold();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/booth_mul_arbiter.md
BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, operand width of the shared Booth multiplier.
REQ-002 Parameter TIMEOUT, default 64, maximum WAIT cycles before watchdog abort; SHALL be > WIDTH+3.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 req0, req1  input  1 each  request from requester 0/1; held high until matching gnt.
REQ-006 a0, b0, a1, b1  input  WIDTH each  multiplicand/multiplier of requester 0/1; valid while req high.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse; operands captured.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_ready  input  1  consumer accepts result.
REQ-010 rsp_id  output  1  requester index owning the result.
REQ-011 rsp_data  output  2*WIDTH  product.
REQ-012 rsp_err  output  1  watchdog abort; rsp_data = 0 when set.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 mul_go  output  1  start pulse to the multiplier.
REQ-015 mul_a, mul_b  output  WIDTH each  operands to the multiplier.
REQ-016 mul_rst  output  1  one-cycle recovery reset to the multiplier.
REQ-017 mul_done  input  1  multiplier completion flag.
REQ-018 mul_p  input  2*WIDTH  multiplier product, valid while mul_done high.

Function
REQ-019 FSM states IDLE, START, WAIT, RESP; all outputs registered or decoded from state only.
REQ-020 IDLE: if any req high, select winner, latch its a/b into mul_a/mul_b, go to START; else stay.
REQ-021 Arbitration round-robin: single req wins; both high -> requester not equal to last_grant wins; last_grant updated on selection.
REQ-022 START: exactly one cycle; mul_go=1 and gnt of winner=1 together; -> WAIT.
REQ-023 Latency: req sampled at edge N in IDLE -> mul_go/gnt high in cycle N+1.
REQ-024 mul_a/mul_b stable from capture until the next capture; never change in START, WAIT or RESP.
REQ-025 WAIT: watchdog counter cleared on entry, increments each WAIT cycle.
REQ-026 WAIT with mul_done=1: capture mul_p into rsp_data, rsp_err=0, -> RESP.
REQ-027 WAIT, counter = TIMEOUT-1, mul_done=0: rsp_data=0, rsp_err=1, mul_rst=1 for one cycle, -> RESP.
REQ-028 mul_done and timeout in same cycle: mul_done wins, no error, no mul_rst.
REQ-029 mul_done in IDLE, START or RESP SHALL be ignored.
REQ-030 RESP: rsp_valid=1, rsp_id = winner; rsp_data/rsp_id/rsp_err held stable until rsp_ready=1.
REQ-031 RESP with rsp_ready=1: -> IDLE next edge; rsp_valid low in IDLE.
REQ-032 Requests arriving while busy SHALL be held off (no gnt) and served in IDLE per REQ-021.
REQ-033 Back-to-back: IDLE with req high right after RESP starts a new transaction without an extra idle cycle.

Reset
REQ-034 RST high: state IDLE; gnt0/gnt1, mul_go, mul_rst, rsp_valid, rsp_err, rsp_id, busy = 0; rsp_data, mul_a, mul_b, counter = 0; last_grant = 1 so requester 0 wins first tie.
REQ-035 RST mid-transaction: pending result discarded, mul_go deasserted immediately, no gnt reissued; requester re-requests.

Verification
REQ-036 req0=1, a0=3, b0=-2 (8-bit) -> gnt0 and mul_go in cycle N+1; after mul_done, rsp_valid=1, rsp_id=0, rsp_data=16'hFFFA, rsp_err=0.
REQ-037 req0=req1=1 from reset, rsp_ready tied 1 -> grant order 0,1,0,1; rsp_id alternates likewise.
REQ-038 Multiplier model never raises mul_done -> after TIMEOUT WAIT cycles: mul_rst pulse, rsp_err=1, rsp_data=0.
REQ-039 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid/rsp_data stable; req1 raised meanwhile gets no gnt until IDLE.
REQ-040 RST asserted in WAIT -> all outputs 0 asynchronously; following req1 served normally.
REQ-041 mul_done forced high in cycle TIMEOUT-1 of WAIT -> normal result, rsp_err=0, no mul_rst.
